// File: rtl/fault_event_logger.sv
// fault_event_logger: timestamped fault-event log with sticky flags and saturating per-source counters (FAULT_LOG_RESULT_CHECK_EN adds result-mismatch source).
// Latency: an event sampled at edge N is visible on log_valid/log_data, counters and sticky after edge N.
// Backpressure: log_ready=0 holds the FIFO head; pushes into a full FIFO without a pop are dropped and set overflow.

module fault_log_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  output logic                     push_rdy,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign pop_vld  = (cnt != '0);
  assign do_pop   = pop_vld && pop_rdy;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_rdy = (cnt != FULL_CNT) || do_pop;
  assign do_push  = push_vld && push_rdy;
  assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;
  assign level    = cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !clr) mem[wr_ptr] <= push_dat;
  end
endmodule

module fault_event_logger #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int TS_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_fault,
  input  logic                          mux_err,
  input  logic                          ecc_serr,
  input  logic                          result_valid,
  input  logic [31:0]                   result_w,
  input  logic [31:0]                   expected_result,
  input  logic                          clr,
  input  logic                          log_ready,
  output logic                          log_valid,
  output logic [4+TS_W-1:0]             log_data,
  output logic [CNT_W-1:0]              alu_cnt,
  output logic [CNT_W-1:0]              mux_cnt,
  output logic [CNT_W-1:0]              ecc_cnt,
  output logic [CNT_W-1:0]              res_cnt,
  output logic [3:0]                    sticky,
  output logic                          any_fault,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
`ifdef FAULT_LOG_RESULT_CHECK_EN
  localparam int NSRC = 4;
`else
  localparam int NSRC = 3;
`endif

  logic [2:0]       prev_q;
  logic [TS_W-1:0]  ts_q;
  logic [3:0]       evt;
  logic             log_en;
  logic             push_rdy;
  logic             ovf_q;
  logic [NSRC-1:0]  sticky_q;
  logic [CNT_W-1:0] cnt_q [NSRC];

  assign evt[0] = alu_fault && !prev_q[0];
  assign evt[1] = mux_err   && !prev_q[1];
  assign evt[2] = ecc_serr  && !prev_q[2];
`ifdef FAULT_LOG_RESULT_CHECK_EN
  // Mismatch is level-sensitive: every qualified bad beat is its own event.
  assign evt[3] = result_valid && (result_w != expected_result);
`else
  logic unused_result_inputs;
  assign evt[3] = 1'b0;
  assign unused_result_inputs = ^{result_valid, result_w, expected_result};
`endif

  // Events in a clr cycle are discarded entirely.
  assign log_en = (evt != 4'b0000) && !clr;

  // Edge history survives clr so a held flag is not re-counted afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 3'b000;
      ts_q   <= '0;
    end else begin
      prev_q <= {ecc_serr, mux_err, alu_fault};
      ts_q   <= ts_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sticky_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < NSRC; i++) cnt_q[i] <= '0;
    end else begin
      if (log_en && !push_rdy) ovf_q <= 1'b1;
      for (int i = 0; i < NSRC; i++) begin
        if (evt[i]) begin
          sticky_q[i] <= 1'b1;
          if (cnt_q[i] != {CNT_W{1'b1}}) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  fault_log_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (4 + TS_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push_vld (log_en),
    .push_dat ({evt, ts_q}),
    .push_rdy (push_rdy),
    .pop_vld  (log_valid),
    .pop_rdy  (log_ready),
    .pop_dat  (log_data),
    .level    (fifo_level)
  );

  assign alu_cnt  = cnt_q[0];
  assign mux_cnt  = cnt_q[1];
  assign ecc_cnt  = cnt_q[2];
`ifdef FAULT_LOG_RESULT_CHECK_EN
  assign res_cnt  = cnt_q[3];
  assign sticky   = sticky_q;
`else
  assign res_cnt  = '0;
  assign sticky   = {1'b0, sticky_q};
`endif
  assign any_fault = |sticky;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_fault_event_logger.sv
// Bench for fault_event_logger: hand tables, directed corner sequences and a randomized run against a queue-based model.
module tb_fault_event_logger;
  localparam int FD = 8;
  localparam int CW = 8;
  localparam int TW = 16;
  localparam int CMAX = (1 << CW) - 1;
`ifdef FAULT_LOG_RESULT_CHECK_EN
  localparam bit RES_EN = 1'b1;
`else
  localparam bit RES_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, alu_fault, mux_err, ecc_serr, result_valid, clr, log_ready;
  logic [31:0] result_w, expected_result;
  logic log_valid;
  logic [4+TW-1:0] log_data;
  logic [CW-1:0] alu_cnt, mux_cnt, ecc_cnt, res_cnt;
  logic [3:0] sticky;
  logic any_fault, overflow;
  logic [$clog2(FD):0] fifo_level;

  fault_event_logger #(.FIFO_DEPTH(FD), .CNT_W(CW), .TS_W(TW)) dut (
    .clk(clk), .rst(rst), .alu_fault(alu_fault), .mux_err(mux_err), .ecc_serr(ecc_serr),
    .result_valid(result_valid), .result_w(result_w), .expected_result(expected_result),
    .clr(clr), .log_ready(log_ready), .log_valid(log_valid), .log_data(log_data),
    .alu_cnt(alu_cnt), .mux_cnt(mux_cnt), .ecc_cnt(ecc_cnt), .res_cnt(res_cnt),
    .sticky(sticky), .any_fault(any_fault), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model: a bounded queue of records plus per-source tallies.
  int            m_ts;
  bit [2:0]      m_prev;
  int            m_cnt [4];
  bit [3:0]      m_sticky;
  bit            m_ovf;
  bit [4+TW-1:0] m_q [$];

  task automatic model_edge();
    bit [3:0] m;
    if (rst) begin
      m_ts = 0; m_prev = 0; m_cnt = '{default: 0}; m_sticky = 0; m_ovf = 0; m_q.delete();
      return;
    end
    m[0] = alu_fault && !m_prev[0];
    m[1] = mux_err   && !m_prev[1];
    m[2] = ecc_serr  && !m_prev[2];
    m[3] = RES_EN && result_valid && (result_w != expected_result);
    if (clr) begin
      m_cnt = '{default: 0}; m_sticky = 0; m_ovf = 0; m_q.delete();
    end else begin
      if (log_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (m != 0) begin
        if (m_q.size() < FD) m_q.push_back({m, m_ts[TW-1:0]});
        else m_ovf = 1;
        for (int i = 0; i < 4; i++)
          if (m[i]) begin
            m_sticky[i] = 1;
            if (m_cnt[i] < CMAX) m_cnt[i]++;
          end
      end
    end
    m_prev = {ecc_serr, mux_err, alu_fault};
    m_ts = (m_ts + 1) % (1 << TW);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    alu_fault = 0; mux_err = 0; ecc_serr = 0; result_valid = 0; clr = 0; log_ready = 0;
    result_w = 0; expected_result = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic cmp_model(input string tag);
    bit [4+TW-1:0] head;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    check({tag, ".log_valid"}, log_valid, m_q.size() > 0);
    check({tag, ".log_data"}, log_data, head);
    check({tag, ".fifo_level"}, fifo_level, m_q.size());
    check({tag, ".alu_cnt"}, alu_cnt, m_cnt[0]);
    check({tag, ".mux_cnt"}, mux_cnt, m_cnt[1]);
    check({tag, ".ecc_cnt"}, ecc_cnt, m_cnt[2]);
    check({tag, ".res_cnt"}, res_cnt, m_cnt[3]);
    check({tag, ".sticky"}, sticky, m_sticky);
    check({tag, ".any_fault"}, any_fault, m_sticky != 0);
    check({tag, ".overflow"}, overflow, m_ovf);
  endtask

  typedef struct {
    bit alu, mux, ecc, clr, rdy;
    bit vld; int lvl; bit [3:0] stk; int ac, mc, ec;
  } vec_t;
  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1,0,0,0,0, 1,1,4'b0001,1,0,0};
    tbl[1]  = '{1,1,0,0,0, 1,2,4'b0011,1,1,0};
    tbl[2]  = '{0,0,0,0,0, 1,2,4'b0011,1,1,0};
    tbl[3]  = '{0,0,0,0,1, 1,1,4'b0011,1,1,0};
    tbl[4]  = '{0,0,0,0,1, 0,0,4'b0011,1,1,0};
    tbl[5]  = '{1,0,0,0,1, 1,1,4'b0011,2,1,0};
    tbl[6]  = '{0,0,0,1,0, 0,0,4'b0000,0,0,0};
    tbl[7]  = '{1,0,0,0,0, 1,1,4'b0001,1,0,0};
    tbl[8]  = '{1,0,0,1,0, 0,0,4'b0000,0,0,0};
    tbl[9]  = '{0,1,0,1,0, 0,0,4'b0000,0,0,0};
    tbl[10] = '{0,1,0,0,0, 0,0,4'b0000,0,0,0};
    tbl[11] = '{0,0,1,0,0, 1,1,4'b0100,0,0,1};

    idle_inputs();
    rst = 1;
    do_reset();
    check("rst.log_valid", log_valid, 0);
    check("rst.log_data", log_data, 0);
    check("rst.fifo_level", fifo_level, 0);
    check("rst.sticky", sticky, 0);
    check("rst.any_fault", any_fault, 0);
    check("rst.overflow", overflow, 0);
    check("rst.alu_cnt", alu_cnt, 0);

    // Table sequence
    for (int i = 0; i < 12; i++) begin
      alu_fault = tbl[i].alu; mux_err = tbl[i].mux; ecc_serr = tbl[i].ecc;
      clr = tbl[i].clr; log_ready = tbl[i].rdy;
      step();
      check($sformatf("tbl%0d.log_valid", i), log_valid, tbl[i].vld);
      check($sformatf("tbl%0d.fifo_level", i), fifo_level, tbl[i].lvl);
      check($sformatf("tbl%0d.sticky", i), sticky, tbl[i].stk);
      check($sformatf("tbl%0d.alu_cnt", i), alu_cnt, tbl[i].ac);
      check($sformatf("tbl%0d.mux_cnt", i), mux_cnt, tbl[i].mc);
      check($sformatf("tbl%0d.ecc_cnt", i), ecc_cnt, tbl[i].ec);
    end

    // Held ALU flag starting at TS=10 gives exactly one record
    do_reset();
    repeat (10) step();
    check("ts10.pre_valid", log_valid, 0);
    alu_fault = 1;
    step();
    check("ts10.log_valid", log_valid, 1);
    check("ts10.log_data", log_data, {4'b0001, 16'h000A});
    repeat (4) step();
    alu_fault = 0;
    check("ts10.alu_cnt", alu_cnt, 1);
    check("ts10.fifo_level", fifo_level, 1);
    check("ts10.sticky", sticky, 4'b0001);

    // Simultaneous ALU + ECC at TS=20 merge into one record
    do_reset();
    repeat (20) step();
    alu_fault = 1; ecc_serr = 1;
    step();
    alu_fault = 0; ecc_serr = 0;
    check("merge.log_data", log_data, {4'b0101, 16'd20});
    check("merge.fifo_level", fifo_level, 1);
    check("merge.alu_cnt", alu_cnt, 1);
    check("merge.ecc_cnt", ecc_cnt, 1);

    // Nine MUX pulses into a depth-8 FIFO, then drain in order
    do_reset();
    for (int i = 0; i < 9; i++) begin
      mux_err = 1; step();
      mux_err = 0; step();
    end
    check("ovf.fifo_level", fifo_level, 8);
    check("ovf.overflow", overflow, 1);
    check("ovf.mux_cnt", mux_cnt, 9);
    log_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d.log_valid", i), log_valid, 1);
      check($sformatf("drain%0d.log_data", i), log_data, {4'b0010, 16'(2 * i)});
      step();
    end
    check("drain.empty", log_valid, 0);
    log_ready = 0;

    // Result mismatch source
    do_reset();
    expected_result = 32'd18;
    result_valid = 1; result_w = 32'd18; step();
    result_w = 32'hDEADBEEF; step();
    result_valid = 0; step();
`ifdef FAULT_LOG_RESULT_CHECK_EN
    check("res.fifo_level", fifo_level, 1);
    check("res.log_data", log_data, {4'b1000, 16'd1});
    check("res.res_cnt", res_cnt, 1);
    check("res.sticky3", sticky[3], 1);
`else
    check("res.fifo_level", fifo_level, 0);
    check("res.res_cnt", res_cnt, 0);
    check("res.sticky", sticky, 0);
`endif

    // Push and pop together while full
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mux_err = 1; step();
      mux_err = 0; step();
    end
    check("fullpp.pre_level", fifo_level, 8);
    mux_err = 1; log_ready = 1;
    step();
    mux_err = 0; log_ready = 0;
    check("fullpp.fifo_level", fifo_level, 8);
    check("fullpp.overflow", overflow, 0);
    check("fullpp.head", log_data, {4'b0010, 16'd2});

    // Counter saturation, then clear
    do_reset();
    log_ready = 1;
    for (int i = 0; i < 300; i++) begin
      alu_fault = 1; step();
      alu_fault = 0; step();
    end
    check("sat.alu_cnt", alu_cnt, 255);
    check("sat.sticky", sticky, 4'b0001);
    log_ready = 0;
    clr = 1; step(); clr = 0;
    check("clr.alu_cnt", alu_cnt, 0);
    check("clr.log_valid", log_valid, 0);
    check("clr.sticky", sticky, 0);
    alu_fault = 1; step();
    check("clr.ts_keeps_counting", log_data, {4'b0001, 16'd601});

    // Reset beats clr, events and handshake; held flag counts after reset
    rst = 1; clr = 1; log_ready = 1; mux_err = 1;
    step();
    check("rstprio.log_valid", log_valid, 0);
    check("rstprio.fifo_level", fifo_level, 0);
    check("rstprio.alu_cnt", alu_cnt, 0);
    check("rstprio.any_fault", any_fault, 0);
    rst = 0; clr = 0; log_ready = 0; mux_err = 0;
    step();
    check("postrst.log_data", log_data, {4'b0001, 16'd0});
    check("postrst.alu_cnt", alu_cnt, 1);
    alu_fault = 0;

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      alu_fault = ($urandom_range(0, 3) == 0);
      mux_err = ($urandom_range(0, 4) == 0);
      ecc_serr = ($urandom_range(0, 5) == 0);
      result_valid = $urandom_range(0, 1);
      expected_result = $urandom();
      result_w = $urandom_range(0, 1) ? expected_result : $urandom();
      log_ready = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
      cmp_model("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fault_event_logger.md
FAULT_EVENT_LOGGER -- requirements
Module: fault_event_logger

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-source saturating counter.
REQ-003 SHALL have parameter TS_W, default 16, timestamp counter width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port alu_fault  input  1  time-redundant ALU hardware fault flag.
REQ-007 SHALL have port mux_err  input  1  writeback mux BIST error flag.
REQ-008 SHALL have port ecc_serr  input  1  data-memory ECC single-bit-corrected flag.
REQ-009 SHALL have port result_valid  input  1  writeback result qualifier.
REQ-010 SHALL have port result_w  input  32  writeback result.
REQ-011 SHALL have port expected_result  input  32  golden value for result check.
REQ-012 SHALL have port clr  input  1  synchronous clear of log state.
REQ-013 SHALL have port log_ready  input  1  consumer accepts log_data.
REQ-014 SHALL have port log_valid  output  1  FIFO non-empty.
REQ-015 SHALL have port log_data  output  4+TS_W  {src_mask[3:0], timestamp}; bit0 ALU, bit1 MUX, bit2 ECC, bit3 result mismatch.
REQ-016 SHALL have ports alu_cnt, mux_cnt, ecc_cnt, res_cnt  output  CNT_W each  per-source event counts.
REQ-017 SHALL have port sticky  output  4  sticky per-source flags, same bit order as src_mask.
REQ-018 SHALL have port any_fault  output  1  OR of sticky.
REQ-019 SHALL have port overflow  output  1  sticky: event dropped due to full FIFO.
REQ-020 SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-021 SHALL detect events on alu_fault, mux_err, ecc_serr as rising edges (input 1, previous-cycle sample 0); a held-high flag yields one event.
REQ-022 SHALL detect a result-mismatch event every cycle result_valid=1 and result_w != expected_result (no edge detection).
REQ-023 SHALL, in the cycle any event occurs, set the matching sticky bits and increment the matching counters at that edge, visible the following cycle.
REQ-024 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 SHALL push exactly one record per cycle with any event; simultaneous events merge into one record with multiple src_mask bits set.
REQ-026 Record timestamp SHALL be the free-running TS_W counter value at the sampling edge; counter increments every cycle, wraps from all-ones to 0.
REQ-027 log_valid SHALL assert the cycle after a push into an empty FIFO (one-cycle latency); log_data SHALL hold the oldest record, stable while log_valid=1 and log_ready=0.
REQ-028 Pop SHALL occur on an edge with log_valid=1 and log_ready=1.
REQ-029 Push while full without a simultaneous pop SHALL drop the record and set overflow; sticky and counters still update.
REQ-030 Push and pop in the same cycle SHALL both succeed, including when full; fifo_level unchanged.
REQ-031 clr SHALL, at the next edge, zero sticky, counters, overflow and empty the FIFO; timestamp counter and edge-detect history are not cleared; events in the clr cycle are discarded.

Reset
REQ-032 rst=1 at an edge SHALL zero all counters, sticky, overflow, timestamp, edge-detect history, FIFO pointers; log_valid=0, log_data=0, fifo_level=0, any_fault=0.
REQ-033 rst SHALL take priority over clr and over any event or handshake in the same cycle, including mid-stream.
REQ-034 A flag already high in the first cycle after rst deasserts SHALL count as a rising edge.

Configuration
REQ-035 With macro FAULT_LOG_RESULT_CHECK_EN defined, result-mismatch detection (REQ-022) SHALL be compiled in.
REQ-036 Without FAULT_LOG_RESULT_CHECK_EN, src_mask[3], sticky[3] and res_cnt SHALL be constant 0 and result_valid, result_w, expected_result ignored.

Verification
REQ-037 Reset, alu_fault high 5 cycles starting TS=10 -> one record {0001,0x000A}, alu_cnt=1, sticky=0001, log_valid high at TS=11.
REQ-038 alu_fault and ecc_serr rise in same cycle at TS=20 -> one record src_mask=0101, alu_cnt=1, ecc_cnt=1.
REQ-039 log_ready=0, 9 separate mux_err pulses with FIFO_DEPTH=8 -> fifo_level=8, overflow=1, mux_cnt=9; drain yields 8 records in order.
REQ-040 Macro defined, expected_result=18, result_valid with result_w=18 then 0xDEADBEEF -> only second beat logged, res_cnt=1, sticky[3]=1; macro undefined -> no record.
REQ-041 FIFO full, push and pop same cycle -> level stays 8, overflow stays 0.
REQ-042 300 ALU pulses with CNT_W=8 -> alu_cnt=255; then clr -> counts 0, log_valid=0, timestamp keeps counting.
